quad_encoder_gen: RTL and testbench

Quadrature encoder emulator: drives the A/B pins of a rotary encoder under command, generating clean Gray-coded steps at a programmable rate in either direction. It is the transmit side of the encoder inputs consumed by the RGB mixer. It is used as an on-chip self-test source and as the stimulus generator in system benches in place of hand-toggled encoder pins.

---
 rtl/quad_encoder_gen.sv | 94 +++++++++
 tb/tb_quad_encoder_gen.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/quad_encoder_gen.sv
// Quadrature encoder emulator: emits Gray-coded A/B steps at a programmable
// edge interval in either direction, under start/abort command control.
module quad_encoder_gen #(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             dir,
    input  logic [CNT_W-1:0] steps,
    input  logic [DIV_W-1:0] edge_div,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             enc_a,
    output logic             enc_b
);

    localparam int unsigned EW = CNT_W + 2;

    typedef enum logic {StIdle, StRun} state_e;

    state_e           state_q;
    logic [1:0]       phase_q;
    logic [EW-1:0]    edge_cnt_q;
    logic [DIV_W-1:0] int_cnt_q;
    logic [DIV_W-1:0] div_q;
    logic             dir_q;

    logic [DIV_W-1:0] div_eff;
    logic [1:0]       phase_nxt;

    always_comb begin
        div_eff   = (edge_div == '0) ? DIV_W'(1) : edge_div;
        phase_nxt = dir_q ? (phase_q + 2'd1) : (phase_q - 2'd1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            phase_q    <= 2'd0;
            edge_cnt_q <= '0;
            int_cnt_q  <= '0;
            div_q      <= '0;
            dir_q      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            enc_a      <= 1'b0;
            enc_b      <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start && !abort) begin
                        if (steps == '0) begin
                            done <= 1'b1;
                        end else begin
                            state_q    <= StRun;
                            busy       <= 1'b1;
                            dir_q      <= dir;
                            div_q      <= div_eff;
                            int_cnt_q  <= div_eff;
                            edge_cnt_q <= {steps, 2'b00};
                        end
                    end
                end
                StRun: begin
                    if (abort) begin
                        // Outputs and phase hold; the pending edge is dropped.
                        state_q <= StIdle;
                        busy    <= 1'b0;
                    end else if (int_cnt_q == DIV_W'(1)) begin
                        // Phase 0..3 maps to (a,b) = 00,10,11,01.
                        phase_q    <= phase_nxt;
                        enc_a      <= phase_nxt[1] ^ phase_nxt[0];
                        enc_b      <= phase_nxt[1];
                        int_cnt_q  <= div_q;
                        edge_cnt_q <= edge_cnt_q - EW'(1);
                        if (edge_cnt_q == EW'(1)) begin
                            state_q <= StIdle;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end
                    end else begin
                        int_cnt_q <= int_cnt_q - DIV_W'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_quad_encoder_gen.sv
// Self-checking bench for quad_encoder_gen: timeline-arithmetic reference model,
// per-cycle compare, directed scenarios with literal sequences, then random traffic.
module tb_quad_encoder_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        dir = 1'b0;
    logic [7:0]  steps = '0;
    logic [15:0] edge_div = '0;
    logic        abort = 1'b0;
    logic        busy, done, enc_a, enc_b;

    quad_encoder_gen dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .dir      (dir),
        .steps    (steps),
        .edge_div (edge_div),
        .abort    (abort),
        .busy     (busy),
        .done     (done),
        .enc_a    (enc_a),
        .enc_b    (enc_b)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a command accepted at edge N with interval D makes edge k
    // land on clock edge N+k*D; the phase is the start phase +/- k (mod 4).
    logic [1:0] ab_of_phase [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
    int         edge_no = 0;
    bit         m_busy = 0, m_done = 0, m_dir = 0;
    int         m_n, m_d, m_total;
    logic [1:0] m_phase = 2'd0, m_base = 2'd0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy  = 0;
            m_done  = 0;
            m_phase = 2'd0;
        end else begin
            edge_no++;
            m_done = 0;
            if (m_busy) begin
                if (abort) begin
                    m_busy = 0;
                end else if ((edge_no - m_n) % m_d == 0) begin
                    int k;
                    k = (edge_no - m_n) / m_d;
                    m_phase = m_dir ? 2'(int'(m_base) + k) : 2'(int'(m_base) - k);
                    if (k == m_total) begin
                        m_busy = 0;
                        m_done = 1;
                    end
                end
            end else if (start && !abort) begin
                if (steps == 0) begin
                    m_done = 1;
                end else begin
                    m_busy  = 1;
                    m_n     = edge_no;
                    m_d     = (edge_div == 0) ? 1 : int'(edge_div);
                    m_total = 4 * int'(steps);
                    m_dir   = dir;
                    m_base  = m_phase;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("cycle_compare", {28'd0, busy, done, enc_a, enc_b},
                  {28'd0, m_busy, m_done, ab_of_phase[m_phase]});
        end
    end

    // Observation of output transitions, busy edges and done pulses.
    logic [1:0] seen [$];
    logic [1:0] exp_q [$];
    logic [1:0] last_ab = 2'b00;
    bit         last_busy = 0;
    int         done_cnt = 0, busy_rises = 0, fall_no = -1;

    always @(negedge clk) begin
        if ({enc_a, enc_b} != last_ab) seen.push_back({enc_a, enc_b});
        last_ab = {enc_a, enc_b};
        if (done) done_cnt++;
        if (busy && !last_busy) busy_rises++;
        if (!busy && last_busy) fall_no = edge_no;
        last_busy = busy;
    end

    task automatic clear_obs();
        seen.delete();
        last_ab    = {enc_a, enc_b};
        last_busy  = busy;
        done_cnt   = 0;
        busy_rises = 0;
        fall_no    = -1;
    endtask

    task automatic check_seq(input string name);
        check({name, "_len"}, seen.size(), exp_q.size());
        for (int i = 0; i < seen.size() && i < exp_q.size(); i++)
            check(name, {30'd0, seen[i]}, {30'd0, exp_q[i]});
    endtask

    // Returns the clock edge number that sampled start.
    task automatic issue(input bit d, input int s, input int div, output int n);
        @(posedge clk);
        #1;
        start    = 1'b1;
        dir      = d;
        steps    = 8'(s);
        edge_div = 16'(div);
        @(posedge clk);
        #1;
        n     = edge_no;
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        bit ok;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("idle_timeout", 32'd1, 32'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int n;
        #1;
        check("reset_outputs", {28'd0, busy, done, enc_a, enc_b}, 32'd0);
        #20;
        rst_n = 1'b1;
        clear_obs();

        // Clockwise, 2 cycles, interval 3.
        issue(1'b1, 2, 3, n);
        wait_idle(100);
        exp_q = '{2'b10, 2'b11, 2'b01, 2'b00, 2'b10, 2'b11, 2'b01, 2'b00};
        check_seq("cw_seq");
        check("cw_busy_len", fall_no - n, 32'd24);
        check("cw_done_cnt", done_cnt, 32'd1);

        // Counter-clockwise, interval 0 treated as 1.
        clear_obs();
        issue(1'b0, 1, 0, n);
        wait_idle(100);
        exp_q = '{2'b01, 2'b11, 2'b10, 2'b00};
        check_seq("ccw_seq");
        check("ccw_busy_len", fall_no - n, 32'd4);
        check("ccw_done_cnt", done_cnt, 32'd1);

        // Zero steps: only a done pulse.
        clear_obs();
        issue(1'b1, 0, 2, n);
        wait_idle(20);
        check("zero_done_cnt", done_cnt, 32'd1);
        check("zero_busy_rises", busy_rises, 32'd0);
        check("zero_no_edges", seen.size(), 32'd0);

        // Abort after the 6th edge (edges at N+4k; abort sampled at N+26).
        clear_obs();
        issue(1'b1, 5, 4, n);
        repeat (25) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        repeat (10) @(negedge clk);
        check("abort_hold", {30'd0, enc_a, enc_b}, 32'd3);
        check("abort_busy", busy, 32'd0);
        check("abort_no_done", done_cnt, 32'd0);
        check("abort_edges", seen.size(), 32'd6);

        clear_obs();
        issue(1'b0, 1, 1, n);
        wait_idle(100);
        exp_q = '{2'b10, 2'b00, 2'b01, 2'b11};
        check_seq("after_abort_seq");
        check("after_abort_done", done_cnt, 32'd1);

        // Start while busy is ignored.
        clear_obs();
        issue(1'b1, 3, 2, n);
        issue(1'b0, 1, 0, n);
        wait_idle(100);
        check("busy_start_edges", seen.size(), 32'd12);
        check("busy_start_final", {30'd0, enc_a, enc_b}, 32'd3);
        check("busy_start_done", done_cnt, 32'd1);

        // Asynchronous reset between edges.
        issue(1'b1, 3, 2, n);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async_reset", {28'd0, busy, done, enc_a, enc_b}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        clear_obs();
        issue(1'b1, 1, 0, n);
        wait_idle(100);
        exp_q = '{2'b10, 2'b11, 2'b01, 2'b00};
        check_seq("post_reset_seq");

        // Maximum step count exercises the full edge-counter width.
        clear_obs();
        issue(1'b1, 255, 0, n);
        wait_idle(1100);
        check("max_busy_len", fall_no - n, 32'd1020);
        check("max_edges", seen.size(), 32'd1020);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            start    = ($urandom_range(0, 5) == 0);
            dir      = 1'($urandom);
            steps    = 8'($urandom_range(0, 3));
            edge_div = 16'($urandom_range(0, 3));
            abort    = ($urandom_range(0, 40) == 0);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        wait_idle(200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
